// File: rtl/nes_pkg.sv
// Shared NES definitions: OAM DMA state encoding and the bus register addresses it uses.
package nes_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HALT,
      ST_ALIGN,
      ST_READ,
      ST_WRITE
   } dma_state_t;

   localparam logic [15:0] DMA_REG_ADDR = 16'h4014;
   localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

endpackage : nes_pkg

// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to the DMA register halts the CPU and copies one
// 256-byte page into PPU OAMDATA as parity-aligned read/write cycle pairs.
module oam_dma #(
   parameter logic [15:0] DMA_REG_ADDR = nes_pkg::DMA_REG_ADDR,
   parameter logic [15:0] OAMDATA_ADDR = nes_pkg::OAMDATA_ADDR,
   parameter int          XFER_LEN     = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr_i,
   input  logic        cpu_rw_i,
   input  logic [7:0]  cpu_data_i,
   output logic        rdy_o,
   output logic        dma_active_o,
   output logic [15:0] dma_addr_o,
   output logic        dma_rw_o,
   output logic [7:0]  dma_data_o,
   input  logic [7:0]  dma_data_i
);
   import nes_pkg::*;

   localparam logic [8:0] LAST_IDX = 9'(XFER_LEN - 1);

   dma_state_t  state;
   logic        par;
   logic [8:0]  idx;
   logic [7:0]  page;
   logic [7:0]  latch;

   logic        trigger;
   logic [8:0]  idx_inc;

   assign trigger    = !cpu_rw_i && (cpu_addr_i == DMA_REG_ADDR);
   assign idx_inc    = idx + 9'd1;
   assign dma_data_o = latch;

   // Outputs are registered, so each transition loads the bus values of the state being entered.
   always_ff @(posedge clk) begin
      // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
      if (!rst) begin
         state        <= ST_IDLE;
         par          <= 1'b0;
         idx          <= '0;
         page         <= '0;
         latch        <= '0;
         rdy_o        <= 1'b1;
         dma_active_o <= 1'b0;
         dma_rw_o     <= 1'b1;
         dma_addr_o   <= '0;
      end else begin
         par <= ~par;
         unique case (state)
            ST_IDLE: begin
               if (trigger) begin
                  page  <= cpu_data_i;
                  idx   <= '0;
                  rdy_o <= 1'b0;
                  state <= ST_HALT;
               end
            end
            ST_HALT: begin
               // par is 1 now means it is 0 next cycle, which is where a READ must land.
               dma_active_o <= 1'b1;
               dma_rw_o     <= 1'b1;
               dma_addr_o   <= {page, idx[7:0]};
               state        <= par ? ST_READ : ST_ALIGN;
            end
            ST_ALIGN: begin
               state <= ST_READ;
            end
            ST_READ: begin
               latch      <= dma_data_i;
               dma_rw_o   <= 1'b0;
               dma_addr_o <= OAMDATA_ADDR;
               state      <= ST_WRITE;
            end
            ST_WRITE: begin
               idx      <= idx_inc;
               dma_rw_o <= 1'b1;
               if (idx == LAST_IDX) begin
                  rdy_o        <= 1'b1;
                  dma_active_o <= 1'b0;
                  state        <= ST_IDLE;
               end else begin
                  dma_addr_o <= {page, idx_inc[7:0]};
                  state      <= ST_READ;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule : oam_dma

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: directed and randomized transfers compared
// cycle by cycle against a bus-sequence model built from page, index and parity arithmetic.
module tb_oam_dma;

   localparam int XFER = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpu_addr;
   logic        cpu_rw;
   logic [7:0]  cpu_data;
   logic        rdy_o;
   logic        dma_active_o;
   logic [15:0] dma_addr_o;
   logic        dma_rw_o;
   logic [7:0]  dma_data_o;
   logic [7:0]  dma_data_i;

   logic [7:0]  mem [0:65535];
   logic        model_par;
   int          vectors     = 0;
   int          miscompares = 0;

   oam_dma dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_addr_i   (cpu_addr),
      .cpu_rw_i     (cpu_rw),
      .cpu_data_i   (cpu_data),
      .rdy_o        (rdy_o),
      .dma_active_o (dma_active_o),
      .dma_addr_o   (dma_addr_o),
      .dma_rw_o     (dma_rw_o),
      .dma_data_o   (dma_data_o),
      .dma_data_i   (dma_data_i)
   );

   always #5 clk = ~clk;

   // Bus memory answers combinationally within the cycle.
   assign dma_data_i = mem[dma_addr_o];

   // Reference parity: cleared by reset, flips on every clock edge after that.
   always @(posedge clk) begin
      if (!rst) model_par <= 1'b0;
      else      model_par <= ~model_par;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_bus();
      cpu_addr = 16'h0000;
      cpu_rw   = 1'b1;
      cpu_data = 8'h00;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rdy"},    32'(rdy_o),        32'd1);
      check({tag, "_active"}, 32'(dma_active_o), 32'd0);
      check({tag, "_rw"},     32'(dma_rw_o),     32'd1);
      check({tag, "_addr"},   32'(dma_addr_o),   32'h0);
      check({tag, "_data"},   32'(dma_data_o),   32'h0);
   endtask

   task automatic fill_pattern();
      for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'hA5;
   endtask

   task automatic fill_random();
      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
   endtask

   // Trigger a transfer from page pg on a cycle whose parity gives the requested
   // alignment, then compare every bus cycle until rdy returns (or until abort).
   task automatic run_xfer(input logic [7:0] pg, input bit want_mis,
                           input bit inject, input int abort_idx);
      bit mis;
      int total;
      int j;
      int i;
      @(negedge clk);
      if (model_par != want_mis) @(negedge clk);
      mis      = model_par;
      cpu_addr = 16'h4014;
      cpu_rw   = 1'b0;
      cpu_data = pg;
      @(negedge clk);
      idle_bus();
      total = 1 + int'(mis) + 2 * XFER;
      for (int k = 0; k < total; k++) begin
         check("rdy_low", 32'(rdy_o), 32'd0);
         if (k == 0) begin
            check("halt_active", 32'(dma_active_o), 32'd0);
         end else if (mis && k == 1) begin
            check("align_active", 32'(dma_active_o), 32'd1);
            check("align_rw",     32'(dma_rw_o),     32'd1);
            check("align_addr",   32'(dma_addr_o),   32'({pg, 8'h00}));
         end else begin
            j = k - 1 - int'(mis);
            i = j / 2;
            check("xfer_active", 32'(dma_active_o), 32'd1);
            if (j % 2 == 0) begin
               check("read_rw",   32'(dma_rw_o),   32'd1);
               check("read_addr", 32'(dma_addr_o), 32'({pg, 8'(i)}));
               check("read_par",  32'(model_par),  32'd0);
            end else begin
               check("write_rw",   32'(dma_rw_o),   32'd0);
               check("write_addr", 32'(dma_addr_o), 32'h2004);
               check("write_data", 32'(dma_data_o), 32'(mem[{pg, 8'(i)}]));
               check("write_par",  32'(model_par),  32'd1);
               if (i == abort_idx) begin
                  rst = 1'b0;
                  @(negedge clk);
                  rst = 1'b1;
                  check_reset_outputs("abort");
                  return;
               end
            end
         end
         if (inject && k == 100) begin
            cpu_addr = 16'h4014;
            cpu_rw   = 1'b0;
            cpu_data = 8'h07;
         end else if (inject && k == 101) begin
            idle_bus();
         end
         @(negedge clk);
      end
      check("done_rdy",    32'(rdy_o),        32'd1);
      check("done_active", 32'(dma_active_o), 32'd0);
      check("done_rw",     32'(dma_rw_o),     32'd1);
   endtask

   initial begin
      rst = 1'b0;
      idle_bus();
      fill_pattern();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;

      // Aligned and misaligned transfers of page 02 with the addr^A5 memory pattern.
      run_xfer(8'h02, 1'b0, 1'b0, -1);
      run_xfer(8'h02, 1'b1, 1'b0, -1);

      // Re-trigger with 07 partway through is ignored; page FF wraps inside its page.
      fill_random();
      run_xfer(8'h02, 1'($urandom), 1'b1, -1);
      run_xfer(8'hFF, 1'($urandom), 1'b0, -1);

      // Reset during the WRITE of index 40, then a clean transfer of page 03.
      run_xfer(8'h11, 1'($urandom), 1'b0, 40);
      run_xfer(8'h03, 1'($urandom), 1'b0, -1);

      // CPU reads of 4014 and writes elsewhere must never start a transfer.
      for (int n = 0; n < 16; n++) begin
         @(negedge clk);
         if (n == 0) begin
            cpu_addr = 16'h4014;
            cpu_rw   = 1'b1;
            cpu_data = 8'h05;
         end else if (n == 1) begin
            cpu_addr = 16'h4015;
            cpu_rw   = 1'b0;
            cpu_data = 8'h05;
         end else begin
            cpu_addr = 16'($urandom);
            if (cpu_addr == 16'h4014) cpu_addr = 16'h4013;
            cpu_rw   = 1'($urandom);
            cpu_data = 8'($urandom);
         end
         if (n > 0) begin
            check("notrig_rdy",    32'(rdy_o),        32'd1);
            check("notrig_active", 32'(dma_active_o), 32'd0);
         end
      end
      @(negedge clk);
      idle_bus();
      check("notrig_rdy_end", 32'(rdy_o), 32'd1);

      // Randomized pages and alignments.
      for (int r = 0; r < 3; r++) begin
         fill_random();
         run_xfer(8'($urandom), 1'($urandom), 1'b0, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_oam_dma

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter DMA_REG_ADDR, default 16'h4014, is the CPU address whose write triggers a transfer.
REQ-002 Parameter OAMDATA_ADDR, default 16'h2004, is the PPU OAMDATA register address targeted by DMA writes.
REQ-003 Parameter XFER_LEN, default 256, is the number of bytes per transfer.
REQ-004 clk  input  1  CPU clock; one rising edge = one CPU cycle; the only clock.
REQ-005 rst  input  1  reset; synchronous, active-low.
REQ-006 cpu_addr_i  input  16  CPU bus address.
REQ-007 cpu_rw_i  input  1  CPU bus direction; 1 = read, 0 = write.
REQ-008 cpu_data_i  input  8  CPU write data; the page number is taken from here.
REQ-009 rdy_o  output  1  CPU ready; 0 halts the CPU.
REQ-010 dma_active_o  output  1  1 = DMA owns the bus; selects dma_* over CPU outputs in the bus mux.
REQ-011 dma_addr_o  output  16  DMA bus address.
REQ-012 dma_rw_o  output  1  DMA bus direction; 1 = read, 0 = write.
REQ-013 dma_data_o  output  8  DMA write data.
REQ-014 dma_data_i  input  8  bus read data; valid combinationally within a READ cycle.

Function
REQ-015 Trigger: cpu_rw_i=0 and cpu_addr_i==DMA_REG_ADDR while in IDLE; page <= cpu_data_i, idx <= 0, next state HALT.
REQ-016 States: IDLE, HALT, ALIGN, READ, WRITE.
REQ-017 Parity: register par toggles every clk, including while IDLE; par=0 after reset.
REQ-018 HALT lasts exactly 1 cycle; rdy_o=0; dma_active_o=0, letting the CPU finish its current cycle.
REQ-019 HALT -> READ if par will be 0 in the next cycle; otherwise HALT -> ALIGN.
REQ-020 ALIGN lasts 1 cycle, dma_active_o=1, dma_rw_o=1, dma_addr_o = {page, idx}, read data discarded; ALIGN -> READ.
REQ-021 READ: dma_active_o=1, dma_rw_o=1, dma_addr_o = {page, idx[7:0]}; latch dma_data_i on the closing edge; READ -> WRITE.
REQ-022 WRITE: dma_active_o=1, dma_rw_o=0, dma_addr_o=OAMDATA_ADDR, dma_data_o = latched byte; idx increments.
REQ-023 Every READ occurs on a par=0 cycle; every WRITE occurs on a par=1 cycle.
REQ-024 WRITE -> READ while idx < XFER_LEN-1 before the increment; the WRITE of idx XFER_LEN-1 -> IDLE.
REQ-025 idx is 9 bits wide so the terminal count is explicit; dma_addr_o uses idx[7:0] only, with no carry into page.
REQ-026 Total halt, in cycles from the trigger edge to rdy_o=1: 1+2*XFER_LEN (513) when aligned, +1 (514) when misaligned.
REQ-027 rdy_o=0 in every state except IDLE; rdy_o returns to 1 in the cycle after the last WRITE.
REQ-028 A DMA_REG_ADDR write seen while not IDLE is ignored, and page is unchanged.
REQ-029 CPU reads of DMA_REG_ADDR never trigger.
REQ-030 When dma_active_o=0, dma_rw_o=1 and dma_addr_o/dma_data_o hold their last value; the bus mux ignores them.
REQ-031 Page 8'hFF with idx[7:0] wrapping is legal; the address sequence stays within page FF.

Reset
REQ-032 In reset: state=IDLE, par=0, idx=0, page=0, latch=0, rdy_o=1, dma_active_o=0, dma_rw_o=1, dma_addr_o=0, dma_data_o=0.
REQ-033 Reset mid-transfer aborts on the next edge with the values of REQ-032; no further bus writes occur; the partial OAM contents are left as-is.

Structure
REQ-034 Shared package nes_pkg holds the dma_state_t enum, DMA_REG_ADDR, and OAMDATA_ADDR.
REQ-035 Single flat module with no sub-module; the FSM, idx counter, parity toggle, and data latch are local.
REQ-036 All outputs are registered, except dma_data_o, which is driven directly from the latch register.

Verification
REQ-037 Trigger a write of 8'h02 to $4014 on a cycle giving aligned parity -> READ $0200, WRITE $2004, ..., READ $02FF, WRITE $2004; rdy_o low for exactly 513 cycles.
REQ-038 Same trigger 1 cycle later (misaligned) -> one ALIGN cycle reading $0200, then the same sequence; rdy_o low for 514 cycles; all READs on par=0.
REQ-039 Bench memory returns addr[7:0]^8'hA5 -> the 256 dma_data_o values in WRITE cycles equal i^8'hA5, in order i=0..255.
REQ-040 Second write to $4014 (data 8'h07) at cycle 100 of a transfer -> ignored; addresses stay in page 02; exactly 256 WRITEs.
REQ-041 rst=0 asserted during the WRITE of idx 40 -> next cycle rdy_o=1, dma_active_o=0, state IDLE; a new trigger with 8'h03 starts cleanly at $0300.
REQ-042 CPU read of $4014, and a CPU write to $4015 -> no transfer; rdy_o stays 1.
